// File: rtl/pipelined_alu_flags_if.sv
// rtl/pipelined_alu_flags_if.sv - operand/result handshake bundle for pipelined_alu_flags
interface pipelined_alu_flags_if #(
    parameter int WIDTH = 32
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [3:0]       FN;
    logic             MUL_EN;
    logic             ACC_EN;
    logic             S;
    logic [WIDTH-1:0] LEFT_OP;
    logic [WIDTH-1:0] RIGHT_OP;
    logic [WIDTH-1:0] ACC_OP;
    logic             SHIFTER_C;
    logic             FLAGS_WE;
    logic [3:0]       FLAGS_IN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] ALU_OUTPUT;
    logic             RD_WE;
    logic [3:0]       FLAGS;

    modport master (
        output IN_VALID, FN, MUL_EN, ACC_EN, S, LEFT_OP, RIGHT_OP, ACC_OP,
               SHIFTER_C, FLAGS_WE, FLAGS_IN, OUT_READY,
        input  IN_READY, OUT_VALID, ALU_OUTPUT, RD_WE, FLAGS
    );

    modport slave (
        input  IN_VALID, FN, MUL_EN, ACC_EN, S, LEFT_OP, RIGHT_OP, ACC_OP,
               SHIFTER_C, FLAGS_WE, FLAGS_IN, OUT_READY,
        output IN_READY, OUT_VALID, ALU_OUTPUT, RD_WE, FLAGS
    );
endinterface

// File: rtl/pipelined_alu_flags.sv
// rtl/pipelined_alu_flags.sv - registered ARM data-processing ALU with NZCV register and iterative MUL/MLA
module pipelined_alu_flags #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic                 CLK,
    input logic                 RST,
    pipelined_alu_flags_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
    logic             mul_s;
    logic [WIDTH-1:0] alu_out_q;
    logic             rd_we_q, out_valid_q;
    logic [3:0]       flags_q, flags_next;

    logic             accept, alu_accept, mul_accept, mul_load, out_free;
    logic [WIDTH-1:0] add_a, add_b, logic_res, alu_res;
    logic [WIDTH:0]   sum;
    logic             add_cin, is_arith, is_test, alu_c, alu_v;

    assign out_free     = !out_valid_q || bus.OUT_READY;
    assign bus.IN_READY = (state == IDLE) && out_free;
    assign accept       = bus.IN_VALID && bus.IN_READY;
    assign alu_accept   = accept && !bus.MUL_EN;
    assign mul_accept   = accept && bus.MUL_EN;
    assign mul_load     = (state == DONE) && out_free;
    assign is_test      = (bus.FN[3:2] == 2'b10);

    assign bus.OUT_VALID  = out_valid_q;
    assign bus.ALU_OUTPUT = alu_out_q;
    assign bus.RD_WE      = rd_we_q;
    assign bus.FLAGS      = flags_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_accept) state_next = MUL;
            MUL:     if (cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
            DONE:    if (mul_load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + cin, so the carry-out is directly ARM's NOT-borrow.
    always_comb begin
        add_a    = bus.LEFT_OP;
        add_b    = bus.RIGHT_OP;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        case (bus.FN)
            4'h2, 4'hA: begin add_b = ~bus.RIGHT_OP; add_cin = 1'b1; end
            4'h3:       begin add_a = bus.RIGHT_OP; add_b = ~bus.LEFT_OP; add_cin = 1'b1; end
            4'h4, 4'hB: add_cin = 1'b0;
            4'h5:       add_cin = flags_q[1];
            4'h6:       begin add_b = ~bus.RIGHT_OP; add_cin = flags_q[1]; end
            4'h7:       begin add_a = bus.RIGHT_OP; add_b = ~bus.LEFT_OP; add_cin = flags_q[1]; end
            default:    is_arith = 1'b0;
        endcase

        case (bus.FN)
            4'h0, 4'h8: logic_res = bus.LEFT_OP & bus.RIGHT_OP;
            4'h1, 4'h9: logic_res = bus.LEFT_OP ^ bus.RIGHT_OP;
            4'hC:       logic_res = bus.LEFT_OP | bus.RIGHT_OP;
            4'hD:       logic_res = bus.RIGHT_OP;
            4'hE:       logic_res = bus.LEFT_OP & ~bus.RIGHT_OP;
            4'hF:       logic_res = ~bus.RIGHT_OP;
            default:    logic_res = '0;
        endcase

        sum     = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        alu_res = is_arith ? sum[WIDTH-1:0] : logic_res;
        alu_c   = is_arith ? sum[WIDTH] : bus.SHIFTER_C;
        alu_v   = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]);
    end

    // External write is the base; the op overrides only the fields it owns.
    always_comb begin
        flags_next = bus.FLAGS_WE ? bus.FLAGS_IN : flags_q;
        if (alu_accept && (bus.S || is_test)) begin
            flags_next[3] = alu_res[WIDTH-1];
            flags_next[2] = (alu_res == '0);
            flags_next[1] = alu_c;
            if (is_arith) flags_next[0] = alu_v;
        end else if (mul_load && mul_s) begin
            flags_next[3] = acc[WIDTH-1];
            flags_next[2] = (acc == '0);
        end
    end

    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            mul_s       <= 1'b0;
            alu_out_q   <= '0;
            rd_we_q     <= 1'b0;
            out_valid_q <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            state   <= state_next;
            flags_q <= flags_next;

            if (alu_accept) begin
                alu_out_q   <= alu_res;
                rd_we_q     <= !is_test;
                out_valid_q <= 1'b1;
            end else if (mul_load) begin
                alu_out_q   <= acc;
                rd_we_q     <= 1'b1;
                out_valid_q <= 1'b1;
            end else if (bus.OUT_READY) begin
                out_valid_q <= 1'b0;
            end

            if (mul_accept) begin
                mcand  <= bus.LEFT_OP;
                mplier <= bus.RIGHT_OP;
                acc    <= bus.ACC_EN ? bus.ACC_OP : '0;
                mul_s  <= bus.S;
                cnt    <= '0;
            end else if (state == MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_alu_flags.sv
// tb/tb_pipelined_alu_flags.sv - directed vector bench for pipelined_alu_flags
module tb_pipelined_alu_flags;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pipelined_alu_flags_if #(.WIDTH(WIDTH)) bus ();

    pipelined_alu_flags #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  fn;
        logic        s;
        logic [31:0] l;
        logic [31:0] r;
        logic        shc;
        logic [3:0]  pre;
        logic [31:0] exp_out;
        logic        exp_rd;
        logic [3:0]  exp_fl;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic [3:0] f);
        bus.FLAGS_WE = 1'b1;
        bus.FLAGS_IN = f;
        @(posedge clk); #1;
        bus.FLAGS_WE = 1'b0;
    endtask

    task automatic drive_alu(input logic [3:0] fn, input logic s, input logic [31:0] l,
                             input logic [31:0] r, input logic shc);
        bus.MUL_EN    = 1'b0;
        bus.ACC_EN    = 1'b0;
        bus.FN        = fn;
        bus.S         = s;
        bus.LEFT_OP   = l;
        bus.RIGHT_OP  = r;
        bus.SHIFTER_C = shc;
        bus.IN_VALID  = 1'b1;
    endtask

    task automatic issue_alu(input logic [3:0] fn, input logic s, input logic [31:0] l,
                             input logic [31:0] r, input logic shc);
        int n;
        drive_alu(fn, s, l, r, shc);
        n = 0;
        while (!bus.IN_READY && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("issue_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic run_mul(input logic [31:0] l, input logic [31:0] r, input logic [31:0] a,
                           input logic acc_en, input logic s, output int lat, output int low);
        bus.MUL_EN   = 1'b1;
        bus.ACC_EN   = acc_en;
        bus.S        = s;
        bus.LEFT_OP  = l;
        bus.RIGHT_OP = r;
        bus.ACC_OP   = a;
        bus.IN_VALID = 1'b1;
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        bus.MUL_EN   = 1'b0;
        lat = 0;
        low = 0;
        while (!bus.OUT_VALID && lat < 100) begin
            if (!bus.IN_READY) low++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, low, seen;

        vecs[0]  = '{4'h4, 1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 4'b0000, 32'h80000000, 1'b1, 4'b1001};
        vecs[1]  = '{4'h2, 1'b1, 32'h00000005, 32'h00000005, 1'b0, 4'b0000, 32'h00000000, 1'b1, 4'b0110};
        vecs[2]  = '{4'hA, 1'b0, 32'h00000003, 32'h00000005, 1'b0, 4'b0000, 32'hFFFFFFFE, 1'b0, 4'b1000};
        vecs[3]  = '{4'hD, 1'b0, 32'h00000000, 32'h00001234, 1'b1, 4'b1000, 32'h00001234, 1'b1, 4'b1000};
        vecs[4]  = '{4'h0, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 4'b0001, 32'h00F000F0, 1'b1, 4'b0011};
        vecs[5]  = '{4'h1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'b0010, 32'h00000000, 1'b1, 4'b0100};
        vecs[6]  = '{4'hE, 1'b1, 32'hFFFF0000, 32'hFF00FF00, 1'b0, 4'b0000, 32'h00FF0000, 1'b1, 4'b0000};
        vecs[7]  = '{4'hF, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 32'hFFFFFFFF, 1'b1, 4'b1010};
        vecs[8]  = '{4'h5, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 4'b0010, 32'h00000000, 1'b1, 4'b0110};
        vecs[9]  = '{4'h3, 1'b1, 32'h00000003, 32'h0000000A, 1'b0, 4'b0000, 32'h00000007, 1'b1, 4'b0010};
        vecs[10] = '{4'h7, 1'b1, 32'h00000003, 32'h0000000A, 1'b0, 4'b0000, 32'h00000006, 1'b1, 4'b0010};
        vecs[11] = '{4'hB, 1'b0, 32'h80000000, 32'h80000000, 1'b0, 4'b0000, 32'h00000000, 1'b0, 4'b0111};
        vecs[12] = '{4'h8, 1'b0, 32'h00000001, 32'h00000002, 1'b1, 4'b1001, 32'h00000000, 1'b0, 4'b0111};
        vecs[13] = '{4'h9, 1'b0, 32'h80000000, 32'h00000000, 1'b0, 4'b0000, 32'h80000000, 1'b0, 4'b1000};
        vecs[14] = '{4'hC, 1'b0, 32'h00000001, 32'h00000002, 1'b0, 4'b0101, 32'h00000003, 1'b1, 4'b0101};
        vecs[15] = '{4'h2, 1'b1, 32'h80000000, 32'h00000001, 1'b0, 4'b0000, 32'h7FFFFFFF, 1'b1, 4'b0011};
        vecs[16] = '{4'h6, 1'b1, 32'h00000005, 32'h00000003, 1'b0, 4'b0000, 32'h00000001, 1'b1, 4'b0010};

        bus.IN_VALID  = 1'b0;
        bus.FN        = 4'h0;
        bus.MUL_EN    = 1'b0;
        bus.ACC_EN    = 1'b0;
        bus.S         = 1'b0;
        bus.LEFT_OP   = '0;
        bus.RIGHT_OP  = '0;
        bus.ACC_OP    = '0;
        bus.SHIFTER_C = 1'b0;
        bus.FLAGS_WE  = 1'b0;
        bus.FLAGS_IN  = 4'b0000;
        bus.OUT_READY = 1'b1;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("reset_alu_output", bus.ALU_OUTPUT, 32'd0);
        chk("reset_rd_we", 32'(bus.RD_WE), 32'd0);
        chk("reset_flags", 32'(bus.FLAGS), 32'd0);
        chk("reset_in_ready", 32'(bus.IN_READY), 32'd1);

        for (int i = 0; i < 17; i++) begin
            set_flags(vecs[i].pre);
            issue_alu(vecs[i].fn, vecs[i].s, vecs[i].l, vecs[i].r, vecs[i].shc);
            chk($sformatf("vec%0d_valid", i), 32'(bus.OUT_VALID), 32'd1);
            chk($sformatf("vec%0d_out", i), bus.ALU_OUTPUT, vecs[i].exp_out);
            chk($sformatf("vec%0d_rd_we", i), 32'(bus.RD_WE), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_flags", i), 32'(bus.FLAGS), 32'(vecs[i].exp_fl));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid_drop", i), 32'(bus.OUT_VALID), 32'd0);
        end

        // SUB then SBC back to back: SBC must see the C produced by SUB
        set_flags(4'b0000);
        drive_alu(4'h2, 1'b1, 32'd5, 32'd5, 1'b0);
        @(posedge clk); #1;
        chk("b2b_sub_out", bus.ALU_OUTPUT, 32'd0);
        chk("b2b_sub_flags", 32'(bus.FLAGS), 32'b0110);
        drive_alu(4'h6, 1'b1, 32'd5, 32'd3, 1'b0);
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        chk("b2b_sbc_valid", 32'(bus.OUT_VALID), 32'd1);
        chk("b2b_sbc_out", bus.ALU_OUTPUT, 32'd2);
        chk("b2b_sbc_flags", 32'(bus.FLAGS), 32'b0010);
        @(posedge clk); #1;

        // External flag write colliding with op flag updates
        bus.FLAGS_WE = 1'b1;
        bus.FLAGS_IN = 4'b1111;
        issue_alu(4'h4, 1'b1, 32'd1, 32'd1, 1'b0);
        bus.FLAGS_WE = 1'b0;
        chk("collide_add_flags", 32'(bus.FLAGS), 32'b0000);
        bus.FLAGS_WE = 1'b1;
        bus.FLAGS_IN = 4'b0001;
        issue_alu(4'hD, 1'b1, 32'd0, 32'd5, 1'b0);
        bus.FLAGS_WE = 1'b0;
        chk("collide_mov_flags", 32'(bus.FLAGS), 32'b0001);
        @(posedge clk); #1;

        // MLA with C and V preset
        set_flags(4'b0011);
        run_mul(32'h00010000, 32'h00010000, 32'h00000007, 1'b1, 1'b1, lat, low);
        chk("mla_latency", 32'(lat), 32'(WIDTH + 1));
        chk("mla_ready_low", 32'(low), 32'(WIDTH + 1));
        chk("mla_out", bus.ALU_OUTPUT, 32'h00000007);
        chk("mla_rd_we", 32'(bus.RD_WE), 32'd1);
        chk("mla_flags", 32'(bus.FLAGS), 32'b0011);
        @(posedge clk); #1;

        set_flags(4'b0010);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b1, lat, low);
        chk("mul_ff_out", bus.ALU_OUTPUT, 32'h00000001);
        chk("mul_ff_flags", 32'(bus.FLAGS), 32'b0010);
        @(posedge clk); #1;

        set_flags(4'b1001);
        run_mul(32'h00012345, 32'h00001000, 32'h0, 1'b0, 1'b0, lat, low);
        chk("mul_nos_out", bus.ALU_OUTPUT, 32'h12345000);
        chk("mul_nos_flags", 32'(bus.FLAGS), 32'b1001);
        @(posedge clk); #1;

        set_flags(4'b0000);
        run_mul(32'h00010000, 32'h00010000, 32'h0, 1'b0, 1'b1, lat, low);
        chk("mul_zero_out", bus.ALU_OUTPUT, 32'h0);
        chk("mul_zero_flags", 32'(bus.FLAGS), 32'b0100);
        @(posedge clk); #1;

        // Backpressure: result held while consumer stalls, queued op waits
        bus.OUT_READY = 1'b0;
        drive_alu(4'h4, 1'b0, 32'd1, 32'd2, 1'b0);
        @(posedge clk); #1;
        chk("bp_first_out", bus.ALU_OUTPUT, 32'd3);
        drive_alu(4'h4, 1'b0, 32'd10, 32'd20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold%0d_ready", i), 32'(bus.IN_READY), 32'd0);
            chk($sformatf("bp_hold%0d_valid", i), 32'(bus.OUT_VALID), 32'd1);
            chk($sformatf("bp_hold%0d_out", i), bus.ALU_OUTPUT, 32'd3);
            @(posedge clk); #1;
        end
        chk("bp_hold_final_out", bus.ALU_OUTPUT, 32'd3);
        bus.OUT_READY = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.IN_READY), 32'd1);
        @(posedge clk); #1;
        chk("bp_queued_valid", 32'(bus.OUT_VALID), 32'd1);
        chk("bp_queued_out", bus.ALU_OUTPUT, 32'd30);
        for (int i = 0; i < 4; i++) begin
            drive_alu(4'h4, 1'b0, 32'(i), 32'd100, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("stream%0d_valid", i), 32'(bus.OUT_VALID), 32'd1);
            chk($sformatf("stream%0d_out", i), bus.ALU_OUTPUT, 32'(i + 100));
        end
        bus.IN_VALID = 1'b0;
        @(posedge clk); #1;

        // Reset during an in-flight multiply
        set_flags(4'b1111);
        bus.MUL_EN   = 1'b1;
        bus.ACC_EN   = 1'b0;
        bus.S        = 1'b1;
        bus.LEFT_OP  = 32'd3;
        bus.RIGHT_OP = 32'd7;
        bus.IN_VALID = 1'b1;
        @(posedge clk); #1;
        bus.IN_VALID = 1'b0;
        bus.MUL_EN   = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mul_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_mul_flags", 32'(bus.FLAGS), 32'd0);
        chk("rst_mul_ready", 32'(bus.IN_READY), 32'd1);
        issue_alu(4'h4, 1'b1, 32'd2, 32'd3, 1'b0);
        chk("post_rst_add_valid", 32'(bus.OUT_VALID), 32'd1);
        chk("post_rst_add_out", bus.ALU_OUTPUT, 32'd5);
        chk("post_rst_add_flags", 32'(bus.FLAGS), 32'b0000);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.OUT_VALID) seen++;
        end
        chk("post_rst_no_stray_mul", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
